// File: rtl/led_status_ctrl.sv
// -----------------------------------------------------------------------------
// led_status_ctrl
//
// Multi-channel front-panel LED / PMOD indicator controller. Each channel is
// run-time selectable between off, solid on, a shared heartbeat, and a
// stretched activity blink driven by per-channel event inputs. A per-channel
// saturating counter of activity rising edges is kept for PS readout.
//
// Ports:
//   clk            fabric clock, all logic on the rising edge
//   rst_n          synchronous active-low reset
//   mode_i         per-channel mode, ch i at [2i+1:2i]
//                  (0 off, 1 solid, 2 heartbeat, 3 activity)
//   act_i          per-channel activity level/strobe, synchronous to clk
//   cnt_clr_i      per-channel counter clear, 1-cycle strobe
//   led_o          registered indicator outputs (inverted when ACTIVE_LOW=1)
//   act_cnt_o      per-channel activity event counts,
//                  ch i at [CNT_W*(i+1)-1:CNT_W*i]
//   tick_o         registered 1-cycle tick strobe, once every PRESC_MAX clocks
//   fsm_state_dbg  per-channel activity FSM state, ch i at [2i+1:2i]
//                  (0 IDLE, 1 ON, 2 OFF)
//
// Handshake semantics: this block has no valid/ready interfaces. act_i is
// sampled every clock; cnt_clr_i is a single-cycle strobe acted on at the
// edge that samples it. There is no back-pressure anywhere.
// -----------------------------------------------------------------------------
module led_status_ctrl #(
    parameter int NUM_CH        = 4,
    parameter int PRESC_MAX     = 125000,
    parameter int HB_W          = 9,
    parameter int STRETCH_TICKS = 50,
    parameter int CNT_W         = 16,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*NUM_CH-1:0]       mode_i,
    input  logic [NUM_CH-1:0]         act_i,
    input  logic [NUM_CH-1:0]         cnt_clr_i,
    output logic [NUM_CH-1:0]         led_o,
    output logic [NUM_CH*CNT_W-1:0]   act_cnt_o,
    output logic                      tick_o,
    output logic [2*NUM_CH-1:0]       fsm_state_dbg
);

    localparam int PW = (PRESC_MAX > 1) ? $clog2(PRESC_MAX) : 1;
    localparam int SW = $clog2(STRETCH_TICKS + 1);

    localparam logic [PW-1:0]    PRESC_LAST   = PW'(PRESC_MAX - 1);
    localparam logic [SW-1:0]    STRETCH_INIT = SW'(STRETCH_TICKS);
    localparam logic [SW-1:0]    SCNT_ONE     = SW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic             LED_INV      = (ACTIVE_LOW != 0);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_SOLID = 2'd1;
    localparam logic [1:0] MODE_HB    = 2'd2;
    localparam logic [1:0] MODE_ACT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } act_state_t;

    // -------------------------------------------------------------------------
    // Prescaler and tick strobe
    // -------------------------------------------------------------------------
    logic [PW-1:0] presc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_o  <= 1'b0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            tick_o  <= 1'b1;
        end else begin
            presc_q <= presc_q + PW'(1);
            tick_o  <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Shared heartbeat: MSB of a free-running tick counter
    // -------------------------------------------------------------------------
    logic [HB_W-1:0] hb_cnt_q;
    logic            hb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
        end else if (tick_o) begin
            hb_cnt_q <= hb_cnt_q + HB_W'(1);
        end
    end

    assign hb = hb_cnt_q[HB_W-1];

    // -------------------------------------------------------------------------
    // Per-channel activity FSM (state register + next-state logic)
    // -------------------------------------------------------------------------
    act_state_t    state_q [NUM_CH];
    act_state_t    state_d [NUM_CH];
    logic [SW-1:0] scnt_q  [NUM_CH];
    logic [SW-1:0] scnt_d  [NUM_CH];
    logic          pend_q  [NUM_CH];
    logic          pend_d  [NUM_CH];
    logic [NUM_CH-1:0] led_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                scnt_q[i]  <= '0;
                pend_q[i]  <= 1'b0;
            end
            led_o <= {NUM_CH{LED_INV}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                scnt_q[i]  <= scnt_d[i];
                pend_q[i]  <= pend_d[i];
            end
            led_o <= led_d;
        end
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            scnt_d[i]  = scnt_q[i];
            pend_d[i]  = pend_q[i];

            if (mode_i[2*i +: 2] != MODE_ACT) begin
                // Leaving activity mode discards any blink in progress.
                state_d[i] = ST_IDLE;
                scnt_d[i]  = '0;
                pend_d[i]  = 1'b0;
            end else begin
                unique case (state_q[i])
                    ST_IDLE: begin
                        if (act_i[i]) begin
                            state_d[i] = ST_ON;
                            scnt_d[i]  = STRETCH_INIT;
                        end
                    end
                    ST_ON: begin
                        // Activity seen while lit is remembered so the
                        // channel relights after the minimum off-time.
                        if (act_i[i]) begin
                            pend_d[i] = 1'b1;
                        end
                        if (tick_o) begin
                            if (scnt_q[i] == SCNT_ONE) begin
                                state_d[i] = ST_OFF;
                                scnt_d[i]  = STRETCH_INIT;
                            end else begin
                                scnt_d[i] = scnt_q[i] - SCNT_ONE;
                            end
                        end
                    end
                    ST_OFF: begin
                        if (act_i[i]) begin
                            pend_d[i] = 1'b1;
                        end
                        if (tick_o) begin
                            if (scnt_q[i] == SCNT_ONE) begin
                                // Expiry consumes the pending flag either way.
                                pend_d[i] = 1'b0;
                                if (pend_q[i] || act_i[i]) begin
                                    state_d[i] = ST_ON;
                                    scnt_d[i]  = STRETCH_INIT;
                                end else begin
                                    state_d[i] = ST_IDLE;
                                    scnt_d[i]  = '0;
                                end
                            end else begin
                                scnt_d[i] = scnt_q[i] - SCNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        scnt_d[i]  = '0;
                        pend_d[i]  = 1'b0;
                    end
                endcase
            end

            // The activity LED follows the next state so it lights on the
            // same edge that samples act_i high.
            unique case (mode_i[2*i +: 2])
                MODE_OFF:   led_d[i] = 1'b0 ^ LED_INV;
                MODE_SOLID: led_d[i] = 1'b1 ^ LED_INV;
                MODE_HB:    led_d[i] = hb ^ LED_INV;
                MODE_ACT:   led_d[i] = (state_d[i] == ST_ON) ^ LED_INV;
                default:    led_d[i] = LED_INV;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Activity event counters (rising edges of act_i, saturating)
    // -------------------------------------------------------------------------
    logic [NUM_CH-1:0] act_q;
    logic [NUM_CH-1:0] act_rise;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];

    assign act_rise = act_i & ~act_q;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr_i[i]) begin
                // A clear coinciding with an event keeps that event.
                cnt_d[i] = act_rise[i] ? CNT_W'(1) : '0;
            end else if (act_rise[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            act_q <= act_i;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output packing
    // -------------------------------------------------------------------------
    always_comb begin
        act_cnt_o     = '0;
        fsm_state_dbg = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            act_cnt_o[CNT_W*i +: CNT_W] = cnt_q[i];
            fsm_state_dbg[2*i +: 2]     = state_q[i];
        end
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
module tb_led_status_ctrl;

  localparam int NUM_CH        = 2;
  localparam int PRESC_MAX     = 4;
  localparam int HB_W          = 3;
  localparam int STRETCH_TICKS = 2;
  localparam int CNT_W         = 3;

  localparam int ST_IDLE = 0;
  localparam int ST_ON   = 1;
  localparam int ST_OFF  = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [2*NUM_CH-1:0]     mode;
  logic [NUM_CH-1:0]       act;
  logic [NUM_CH-1:0]       clr;

  logic [NUM_CH-1:0]       led;
  logic [NUM_CH*CNT_W-1:0] cnt;
  logic                    tick;
  logic [2*NUM_CH-1:0]     dbg;

  logic [NUM_CH-1:0]       led_al;
  logic [NUM_CH*CNT_W-1:0] cnt_al;
  logic                    tick_al;
  logic [2*NUM_CH-1:0]     dbg_al;

  always #5 clk = ~clk;

  led_status_ctrl #(
    .NUM_CH(NUM_CH), .PRESC_MAX(PRESC_MAX), .HB_W(HB_W),
    .STRETCH_TICKS(STRETCH_TICKS), .CNT_W(CNT_W), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .act_i(act), .cnt_clr_i(clr),
    .led_o(led), .act_cnt_o(cnt), .tick_o(tick), .fsm_state_dbg(dbg)
  );

  led_status_ctrl #(
    .NUM_CH(NUM_CH), .PRESC_MAX(PRESC_MAX), .HB_W(HB_W),
    .STRETCH_TICKS(STRETCH_TICKS), .CNT_W(CNT_W), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .act_i(act), .cnt_clr_i(clr),
    .led_o(led_al), .act_cnt_o(cnt_al), .tick_o(tick_al), .fsm_state_dbg(dbg_al)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;
  int k = 0;   // edges since the most recent reset release
  logic [CNT_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change and outputs are sampled 1 unit after posedge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic step_to(input int target);
    while (k < target) step();
  endtask

  task automatic wait_tick();
    int n;
    step();
    n = 1;
    while (tick !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check("wait_tick", 32'(tick), 1);
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t;
    rst_n = 1'b0;
    mode  = '0;
    act   = '0;
    clr   = '0;
    repeat (3) step();

    check("rst_led",    32'(led), 0);
    check("rst_led_al", 32'(led_al), 32'h3);
    check("rst_tick",   32'(tick), 0);
    check("rst_cnt",    32'(cnt), 0);
    check("rst_state",  32'(dbg), 0);

    // 1: tick every 4 clocks from release, LEDs off
    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("tick_k%0d", k), 32'(tick), ((k % 4) == 0) ? 1 : 0);
    end
    check("off_led",    32'(led), 0);
    check("off_led_al", 32'(led_al), 32'h3);

    // 2: ch0 heartbeat, ch1 solid
    set_mode(0, 2'd2);
    set_mode(1, 2'd1);
    step_to(13);
    check("solid_led1",  32'(led[1]), 1);
    check("hb_k13",      32'(led[0]), 0);
    check("mode_led_al", 32'(led_al), 32'h1);
    step_to(17); check("hb_k17", 32'(led[0]), 0);
    step_to(18); check("hb_k18", 32'(led[0]), 1);
    step_to(33); check("hb_k33", 32'(led[0]), 1);
    step_to(34); check("hb_k34", 32'(led[0]), 0);
    step_to(49); check("hb_k49", 32'(led[0]), 0);
    step_to(50); check("hb_k50", 32'(led[0]), 1);

    // 3: single activity pulse on ch0
    set_mode(0, 2'd3);
    wait_tick();
    t = k;
    step_to(t + 1); act[0] = 1'b1;
    step_to(t + 2); act[0] = 1'b0;
    check("pulse_led_on",  32'(led[0]), 1);
    check("pulse_st_on",   32'(dbg[1:0]), ST_ON);
    step_to(t + 3); check("pulse_cnt0", 32'(cnt[2:0]), 1);
    step_to(t + 8); check("pulse_led_t8", 32'(led[0]), 1);
    step_to(t + 9);
    check("pulse_led_off", 32'(led[0]), 0);
    check("pulse_st_off",  32'(dbg[1:0]), ST_OFF);
    step_to(t + 17);
    check("pulse_st_idle", 32'(dbg[1:0]), ST_IDLE);
    check("pulse_led_idle", 32'(led[0]), 0);

    // 4: held activity -> 8 clk on / 8 clk off square wave
    wait_tick();
    t = k;
    step_to(t + 1); act[0] = 1'b1;
    step_to(t + 2);  check("held_t2",  32'(led[0]), 1);
    step_to(t + 9);  check("held_t9",  32'(led[0]), 0);
    step_to(t + 16); check("held_t16", 32'(led[0]), 0);
    step_to(t + 17); check("held_t17", 32'(led[0]), 1);
    step_to(t + 24); check("held_t24", 32'(led[0]), 1);
    step_to(t + 25); check("held_t25", 32'(led[0]), 0);
    step_to(t + 32); check("held_t32", 32'(led[0]), 0);
    step_to(t + 33); check("held_t33", 32'(led[0]), 1);
    step_to(t + 41); act[0] = 1'b0;
    check("held_t41_st", 32'(dbg[1:0]), ST_OFF);
    step_to(t + 49); check("held_pend_relight", 32'(led[0]), 1);
    step_to(t + 57); check("held_t57_st", 32'(dbg[1:0]), ST_OFF);
    step_to(t + 65); check("held_t65_idle", 32'(dbg[1:0]), ST_IDLE);

    // 4b: second pulse during OFF relights at OFF expiry
    wait_tick();
    t = k;
    step_to(t + 1); act[0] = 1'b1;
    step_to(t + 2); act[0] = 1'b0;
    check("p2_st_on", 32'(dbg[1:0]), ST_ON);
    step_to(t + 9); check("p2_led_off", 32'(led[0]), 0);
    step_to(t + 11); act[0] = 1'b1;
    step_to(t + 12); act[0] = 1'b0;
    check("p2_st_off_pend", 32'(dbg[1:0]), ST_OFF);
    step_to(t + 16); check("p2_t16", 32'(led[0]), 0);
    step_to(t + 17);
    check("p2_relight",    32'(led[0]), 1);
    check("p2_relight_st", 32'(dbg[1:0]), ST_ON);
    step_to(t + 33);
    check("p2_idle", 32'(dbg[1:0]), ST_IDLE);
    check("cnt0_total", 32'(cnt[2:0]), 4);

    // 5: ch1 counter saturation and clear
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
    for (int p = 1; p <= 9; p++) begin
      act[1] = 1'b1;
      step();
      check($sformatf("sat_cnt1_p%0d", p), 32'(cnt[5:3]), 32'(exp_q.pop_front()));
      act[1] = 1'b0;
      step();
    end
    check("sat_led1_solid", 32'(led[1]), 1);
    act[1] = 1'b1; clr[1] = 1'b1;
    step();
    check("clr_with_edge", 32'(cnt[5:3]), 1);
    act[1] = 1'b0; clr[1] = 1'b0;
    step();
    clr[1] = 1'b1;
    step();
    clr[1] = 1'b0;
    check("clr_alone", 32'(cnt[5:3]), 0);
    check("clr_ch0_kept", 32'(cnt[2:0]), 4);

    // 6a: mode 3 -> 0 mid-ON with pending set
    wait_tick();
    t = k;
    step_to(t + 1); act[0] = 1'b1;
    step_to(t + 3);
    check("m30_st_on", 32'(dbg[1:0]), ST_ON);
    act[0] = 1'b0;
    set_mode(0, 2'd0);
    step();
    check("m30_led", 32'(led[0]), 0);
    check("m30_st",  32'(dbg[1:0]), ST_IDLE);
    set_mode(0, 2'd3);
    step_to(t + 14);
    check("m3_reenter_st",  32'(dbg[1:0]), ST_IDLE);
    check("m3_reenter_led", 32'(led[0]), 0);
    wait_tick();
    t = k;
    step_to(t + 1); act[0] = 1'b1;
    step_to(t + 2); act[0] = 1'b0;
    step_to(t + 9);  check("nopend_off", 32'(dbg[1:0]), ST_OFF);
    step_to(t + 17);
    check("nopend_idle", 32'(dbg[1:0]), ST_IDLE);
    check("nopend_led",  32'(led[0]), 0);

    // 6b: reset mid-ON
    wait_tick();
    t = k;
    step_to(t + 1); act[0] = 1'b1;
    step_to(t + 2); act[0] = 1'b0;
    check("rst2_pre_on", 32'(dbg[1:0]), ST_ON);
    rst_n = 1'b0;
    step();
    check("rst2_led",    32'(led), 0);
    check("rst2_led_al", 32'(led_al), 32'h3);
    check("rst2_state",  32'(dbg), 0);
    check("rst2_tick",   32'(tick), 0);
    check("rst2_cnt",    32'(cnt), 0);
    rst_n = 1'b1;
    k = 0;
    step_to(1); check("rst2_solid_k1", 32'(led[1]), 1);
    step_to(3); check("rst2_tick_k3", 32'(tick), 0);
    step_to(4);
    check("rst2_tick_k4", 32'(tick), 1);
    check("rst2_st_k4",   32'(dbg[1:0]), ST_IDLE);
    check("rst2_led0_k4", 32'(led[0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
